// File: rtl/score_board_n.sv
// Quiz scoreboard for N contestants: debounced add/sub/clear keys, per-contestant
// saturating or wrapping score arithmetic, registered leader index and tie flag.
module score_board_n #(
  parameter int unsigned N_PLAYERS  = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned SCORE_W    = 4,
  parameter int unsigned SCORE_INIT = 5,
  parameter int unsigned SCORE_MAX  = 9,
  parameter int unsigned STEP       = 1,
  parameter int unsigned WRAP       = 1,
  parameter int unsigned DEB_CNT    = 240000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           add_n,
  input  logic                           sub_n,
  input  logic                           clr_n,
  input  logic [N_PLAYERS-1:0]           sel_n,
  output logic [N_PLAYERS*SCORE_W-1:0]   scores,
  output logic                           upd,
  output logic [IDX_W-1:0]               leader_idx,
  output logic                           leader_tie
);

  localparam int unsigned N_KEYS  = 3;
  localparam int unsigned KEY_ADD = 0;
  localparam int unsigned KEY_SUB = 1;
  localparam int unsigned KEY_CLR = 2;
  localparam int unsigned CNT_W   = $clog2(DEB_CNT);
  localparam int unsigned SUM_W   = SCORE_W + 1;
  localparam int unsigned TIE_W   = $clog2(N_PLAYERS + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CNT - 1);
  localparam logic [SCORE_W-1:0] INIT_V   = SCORE_W'(SCORE_INIT);
  localparam logic [SCORE_W-1:0] MAX_V    = SCORE_W'(SCORE_MAX);
  localparam logic [SCORE_W-1:0] STEP_V   = SCORE_W'(STEP);
  localparam logic [SUM_W-1:0]   MAX_S    = SUM_W'(SCORE_MAX);
  localparam logic [SUM_W-1:0]   STEP_S   = SUM_W'(STEP);
  localparam logic [SUM_W-1:0]   MOD_S    = SUM_W'(SCORE_MAX + 1);

  logic [N_KEYS-1:0]             key_raw;
  logic [N_KEYS-1:0]             meta_q, meta_d;
  logic [N_KEYS-1:0]             sync_q, sync_d;
  logic [N_KEYS-1:0]             deb_q, deb_d;
  logic [N_KEYS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]                    press_q, press_d;

  logic [N_PLAYERS-1:0][SCORE_W-1:0] scores_q, scores_d;
  logic                              chg_q, chg_d;
  logic                              upd_q, upd_d;
  logic [IDX_W-1:0]                  leader_idx_q, leader_idx_d;
  logic                              leader_tie_q, leader_tie_d;
  logic [SCORE_W-1:0]                max_v;
  logic [TIE_W-1:0]                  n_max;

  assign key_raw = {clr_n, sub_n, add_n};

  function automatic logic [SCORE_W-1:0] add_step(input logic [SCORE_W-1:0] s);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, s} + STEP_S;
    if (sum <= MAX_S) begin
      return sum[SCORE_W-1:0];
    end else if (WRAP == 0) begin
      return MAX_V;
    end else begin
      sum = sum - MOD_S;
      return sum[SCORE_W-1:0];
    end
  endfunction

  function automatic logic [SCORE_W-1:0] sub_step(input logic [SCORE_W-1:0] s);
    logic [SUM_W-1:0] sum;
    if (s >= STEP_V) begin
      return s - STEP_V;
    end else if (WRAP == 0) begin
      return '0;
    end else begin
      sum = {1'b0, s} + MOD_S - STEP_S;
      return sum[SCORE_W-1:0];
    end
  endfunction

  // Synchroniser plus stability counter per key; a press is a debounced 1->0 edge.
  always_comb begin
    meta_d  = key_raw;
    sync_d  = meta_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    press_d = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (sync_q[k] == deb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        deb_d[k] = sync_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
    press_d[KEY_ADD] = deb_q[KEY_ADD] & ~deb_d[KEY_ADD];
    press_d[KEY_SUB] = deb_q[KEY_SUB] & ~deb_d[KEY_SUB];
  end

  // Clear level dominates; add beats sub when both pulse together.
  always_comb begin
    scores_d = scores_q;
    if (!deb_q[KEY_CLR]) begin
      for (int i = 0; i < N_PLAYERS; i++) scores_d[i] = INIT_V;
    end else if (press_q[KEY_ADD]) begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (!sel_n[i]) scores_d[i] = add_step(scores_q[i]);
      end
    end else if (press_q[KEY_SUB]) begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (!sel_n[i]) scores_d[i] = sub_step(scores_q[i]);
      end
    end
    chg_d = (scores_d != scores_q);
    upd_d = chg_q;
  end

  // Leader search over the registered scores; strict '>' keeps the lowest index on ties.
  always_comb begin
    max_v        = scores_q[0];
    leader_idx_d = '0;
    n_max        = '0;
    for (int i = 1; i < N_PLAYERS; i++) begin
      if (scores_q[i] > max_v) begin
        max_v        = scores_q[i];
        leader_idx_d = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (scores_q[i] == max_v) n_max = n_max + TIE_W'(1);
    end
    leader_tie_d = (n_max > TIE_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q       <= '1;
      sync_q       <= '1;
      deb_q        <= '1;
      cnt_q        <= '0;
      press_q      <= '0;
      scores_q     <= {N_PLAYERS{INIT_V}};
      chg_q        <= 1'b0;
      upd_q        <= 1'b0;
      leader_idx_q <= '0;
      leader_tie_q <= 1'b1;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      deb_q        <= deb_d;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
      scores_q     <= scores_d;
      chg_q        <= chg_d;
      upd_q        <= upd_d;
      leader_idx_q <= leader_idx_d;
      leader_tie_q <= leader_tie_d;
    end
  end

  assign scores     = scores_q;
  assign upd        = upd_q;
  assign leader_idx = leader_idx_q;
  assign leader_tie = leader_tie_q;

endmodule

// File: tb/tb_score_board_n.sv
// Directed bench for score_board_n: three instances (wrap step 1, saturate step 1,
// wrap step 3) share the buttons; expectations are queued from a reference model.
module tb_score_board_n;

  logic        clk = 1'b0;
  logic        rst_n, add_n, sub_n, clr_n;
  logic [3:0]  sel_n;
  logic [15:0] sc_w, sc_s, sc_3;
  logic        upd_w, upd_s, upd_3;
  logic [1:0]  li_w, li_s, li_3;
  logic        lt_w, lt_s, lt_3;

  always #5 clk = ~clk;

  score_board_n #(.DEB_CNT(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .add_n(add_n), .sub_n(sub_n), .clr_n(clr_n), .sel_n(sel_n),
    .scores(sc_w), .upd(upd_w), .leader_idx(li_w), .leader_tie(lt_w));

  score_board_n #(.DEB_CNT(4), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .add_n(add_n), .sub_n(sub_n), .clr_n(clr_n), .sel_n(sel_n),
    .scores(sc_s), .upd(upd_s), .leader_idx(li_s), .leader_tie(lt_s));

  score_board_n #(.DEB_CNT(4), .STEP(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .add_n(add_n), .sub_n(sub_n), .clr_n(clr_n), .sel_n(sel_n),
    .scores(sc_3), .upd(upd_3), .leader_idx(li_3), .leader_tie(lt_3));

  typedef struct {
    string       tag;
    int          dut;
    logic [15:0] sc;
    int          upd_n;
    logic [1:0]  lidx;
    logic        ltie;
  } exp_t;

  exp_t exp_q[$];
  int   m[3][4];
  int   stp[3]     = '{1, 1, 3};
  int   wrp[3]     = '{1, 0, 1};
  int   exp_upd[3] = '{0, 0, 0};
  int   cnt_upd[3] = '{0, 0, 0};
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  always @(posedge clk) begin
    if (upd_w) cnt_upd[0] <= cnt_upd[0] + 1;
    if (upd_s) cnt_upd[1] <= cnt_upd[1] + 1;
    if (upd_3) cnt_upd[2] <= cnt_upd[2] + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, expv);
    end
  endtask

  function automatic logic [15:0] obs_sc(input int d);
    case (d)
      0:       return sc_w;
      1:       return sc_s;
      default: return sc_3;
    endcase
  endfunction

  function automatic logic [1:0] obs_li(input int d);
    case (d)
      0:       return li_w;
      1:       return li_s;
      default: return li_3;
    endcase
  endfunction

  function automatic logic obs_lt(input int d);
    case (d)
      0:       return lt_w;
      1:       return lt_s;
      default: return lt_3;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4; i++) m[d][i] = 5;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      bit any = 0;
      for (int i = 0; i < 4; i++) begin
        if (m[d][i] != 5) any = 1;
        m[d][i] = 5;
      end
      if (any) exp_upd[d]++;
    end
  endtask

  // Scores live in 0..9; out-of-range results either clamp or fold back by 10.
  task automatic model_press(input bit is_add, input logic [3:0] sel);
    for (int d = 0; d < 3; d++) begin
      bit changed = 0;
      for (int i = 0; i < 4; i++) begin
        if (!sel[i]) begin
          int v;
          v = is_add ? m[d][i] + stp[d] : m[d][i] - stp[d];
          if (v > 9) v = (wrp[d] != 0) ? v - 10 : 9;
          if (v < 0) v = (wrp[d] != 0) ? v + 10 : 0;
          if (v != m[d][i]) changed = 1;
          m[d][i] = v;
        end
      end
      if (changed) exp_upd[d]++;
    end
  endtask

  task automatic push_exp(input string tag);
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      int   best, n_at;
      e.tag = tag;
      e.dut = d;
      e.sc  = '0;
      best  = 0;
      n_at  = 0;
      for (int i = 0; i < 4; i++) begin
        e.sc[i*4 +: 4] = 4'(m[d][i]);
        if (m[d][i] > m[d][best]) best = i;
      end
      for (int i = 0; i < 4; i++) if (m[d][i] == m[d][best]) n_at++;
      e.upd_n = exp_upd[d];
      e.lidx  = 2'(best);
      e.ltie  = (n_at > 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_out();
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, "_scores"}, e.dut, 32'(obs_sc(e.dut)), 32'(e.sc));
      chk({e.tag, "_updcnt"}, e.dut, 32'(cnt_upd[e.dut]), 32'(e.upd_n));
      chk({e.tag, "_lidx"}, e.dut, 32'(obs_li(e.dut)), 32'(e.lidx));
      chk({e.tag, "_ltie"}, e.dut, 32'(obs_lt(e.dut)), 32'(e.ltie));
    end
  endtask

  task automatic press(input string tag, input bit do_add, input bit do_sub, input logic [3:0] sel);
    sel_n = sel;
    cyc(2);
    if (do_add) model_press(1'b1, sel);
    else if (do_sub) model_press(1'b0, sel);
    push_exp(tag);
    add_n = !do_add;
    sub_n = !do_sub;
    cyc(10);
    add_n = 1'b1;
    sub_n = 1'b1;
    cyc(10);
    check_out();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    add_n = 1'b1;
    sub_n = 1'b1;
    clr_n = 1'b1;
    sel_n = 4'b1111;
    model_reset();
    cyc(3);
    push_exp("reset");
    check_out();
    rst_n = 1'b1;
    cyc(3);

    // First press: score moves at P+1, upd follows one cycle later.
    sel_n = 4'b1110;
    cyc(2);
    model_press(1'b1, sel_n);
    push_exp("t1_add");
    add_n = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(1);
      if (sc_w[3:0] != 4'd5) seen = 1;
    end
    chk("t1_score_seen", 0, 32'(seen), 32'd1);
    chk("t1_upd_lag", 0, 32'(upd_w), 32'd0);
    cyc(1);
    chk("t1_upd_pulse", 0, 32'(upd_w), 32'd1);
    chk("t1_lidx_p2", 0, 32'(li_w), 32'd0);
    chk("t1_ltie_p2", 0, 32'(lt_w), 32'd0);
    cyc(8);
    add_n = 1'b1;
    cyc(10);
    check_out();

    // Bouncing contact then a firm hold: one increment.
    sel_n = 4'b1110;
    cyc(2);
    for (int k = 0; k < 3; k++) begin
      add_n = 1'b0;
      cyc(2);
      add_n = 1'b1;
      cyc(2);
    end
    model_press(1'b1, sel_n);
    push_exp("t2_bounce");
    add_n = 1'b0;
    cyc(10);
    add_n = 1'b1;
    cyc(10);
    check_out();

    // Short glitch must not register.
    add_n = 1'b0;
    cyc(3);
    add_n = 1'b1;
    cyc(10);
    push_exp("t2_glitch");
    check_out();

    // Fill contestant 0 to the top, then push past it.
    press("t3_fill", 1'b1, 1'b0, 4'b1110);
    press("t3_fill", 1'b1, 1'b0, 4'b1110);
    for (int k = 0; k < 4; k++) press("t3_over", 1'b1, 1'b0, 4'b1110);
    for (int k = 0; k < 5; k++) press("t3_drain", 1'b0, 1'b1, 4'b1011);
    press("t3_under", 1'b0, 1'b1, 4'b1011);

    // Clear held while add presses arrive.
    sel_n = 4'b0000;
    clr_n = 1'b0;
    cyc(8);
    model_clear();
    add_n = 1'b0;
    cyc(10);
    add_n = 1'b1;
    cyc(10);
    push_exp("t5_clr_hold");
    check_out();
    clr_n = 1'b1;
    cyc(10);
    push_exp("t5_clr_rel");
    check_out();

    press("t4_multi", 1'b1, 1'b0, 4'b0101);
    press("t5_addsub", 1'b1, 1'b1, 4'b1110);
    press("t6_add", 1'b1, 1'b0, 4'b1110);
    press("t6_sub", 1'b0, 1'b1, 4'b1110);

    // Reset while the add key is mid-debounce.
    sel_n = 4'b1110;
    add_n = 1'b0;
    cyc(3);
    rst_n = 1'b0;
    model_reset();
    cyc(2);
    add_n = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    cyc(12);
    push_exp("t6_rst");
    check_out();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
